id_ex_reg: RTL

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS core. It captures the decoded control word, register operands, immediate and register specifiers from decode, and presents them to execute one cycle later. When an instruction in EX is a load whose destination is read by the instruction in ID, it inserts a one-cycle bubble and raises a stall to the PC and IF/ID registers. It also squashes on taken branch/jump and counts load-use bubbles for performance monitoring.

---
 rtl/id_ex_reg.sv | 70 +++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection,
// branch squash, global hold and a saturating bubble counter.
module id_ex_reg (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] control_i,
   input  logic [31:0] rs_data_i,
   input  logic [31:0] rt_data_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [5:0]  funct_i,
   input  logic        flush_i,
   input  logic        hold_i,
   output logic [7:0]  ex_control_o,
   output logic [31:0] ex_rs_data_o,
   output logic [31:0] ex_rt_data_o,
   output logic [31:0] ex_imm_o,
   output logic [4:0]  ex_rs_o,
   output logic [4:0]  ex_rt_o,
   output logic [4:0]  ex_rd_o,
   output logic [5:0]  ex_funct_o,
   output logic        stall_o,
   output logic [15:0] bubble_cnt_o
);

   logic ex_mem_read;
   logic rt_hit;
   logic hz;
   logic bubble;
   logic cnt_sat;
   logic unused_ctrl;

   assign unused_ctrl = ^control_i[31:8];

   assign ex_mem_read = ex_control_o[3];
   assign rt_hit      = (ex_rt_o == rs_i) | (ex_rt_o == rt_i);
   assign hz          = ex_mem_read & (ex_rt_o != 5'd0) & rt_hit;
   assign stall_o     = hz;
   assign bubble      = hz | flush_i;
   assign cnt_sat     = (bubble_cnt_o == 16'hFFFF);

   // Bubbles zero only the control word; the operand fields are don't-care.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_control_o <= 8'd0;
         ex_rs_data_o <= 32'd0;
         ex_rt_data_o <= 32'd0;
         ex_imm_o     <= 32'd0;
         ex_rs_o      <= 5'd0;
         ex_rt_o      <= 5'd0;
         ex_rd_o      <= 5'd0;
         ex_funct_o   <= 6'd0;
         bubble_cnt_o <= 16'd0;
      end else if (!hold_i) begin
         ex_control_o <= bubble ? 8'd0 : control_i[7:0];
         ex_rs_data_o <= rs_data_i;
         ex_rt_data_o <= rt_data_i;
         ex_imm_o     <= imm_i;
         ex_rs_o      <= rs_i;
         ex_rt_o      <= rt_i;
         ex_rd_o      <= rd_i;
         ex_funct_o   <= funct_i;
         if (hz && !cnt_sat)
            bubble_cnt_o <= bubble_cnt_o + 16'd1;
      end
   end

endmodule
